// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM / palette access arbiter between render fetch and CPU
// One access per cycle: combinational grant, registered issue stage, registered response valid.
module vram_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rendering,
  input  logic        r_req,
  input  logic [15:0] r_addr,
  output logic        r_gnt,
  output logic [7:0]  r_rdata,
  output logic        r_rvalid,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [15:0] c_addr,
  input  logic [7:0]  c_wdata,
  output logic        c_gnt,
  output logic [7:0]  c_rdata,
  output logic        c_rvalid,
  output logic [15:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [4:0]  pal_addr,
  output logic        pal_we,
  output logic [7:0]  pal_wdata,
  input  logic [7:0]  pal_rdata
);

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  logic [7:0]  r_wait_cnt;
  logic        r_iss_valid;
  logic        r_iss_cpu;
  logic        r_iss_pal;
  logic        r_rsp_pal;

  logic        w_c_win;
  logic        w_r_win;
  logic        w_any;
  logic [13:0] w_eff;
  logic        w_pal_hit;
  logic        w_we;
  logic [7:0]  w_wdata;
  logic [4:0]  w_pal_idx;
  logic [7:0]  w_rdata;
  logic        w_unused;

  // CPU wins outright when rendering is off, when render is idle, or once it has starved long enough
  always_comb begin
    w_c_win = 1'b0;
    if (!reset && c_req) begin
      if (!rendering || !r_req || (r_wait_cnt >= LP_MAX_WAIT)) begin
        w_c_win = 1'b1;
      end
    end
  end

  assign w_r_win   = !reset && r_req && !w_c_win;
  assign w_any     = w_c_win || w_r_win;
  assign w_eff     = w_c_win ? c_addr[13:0] : r_addr[13:0];
  assign w_pal_hit = (w_eff[13:8] == 6'h3F);
  assign w_we      = w_c_win && c_we;
  assign w_wdata   = w_c_win ? c_wdata : 8'h00;

  assign r_gnt = w_r_win;
  assign c_gnt = w_c_win;

  // Sprite-palette entry 0 of each group aliases the matching background entry
  always_comb begin
    w_pal_idx = w_eff[4:0];
    if (w_pal_idx[4] && (w_pal_idx[1:0] == 2'b00)) begin
      w_pal_idx[4] = 1'b0;
    end
  end

  assign w_unused = &{1'b0, c_addr[15:14], r_addr[15:14]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt  <= 8'h00;
      r_iss_valid <= 1'b0;
      r_iss_cpu   <= 1'b0;
      r_iss_pal   <= 1'b0;
      r_rsp_pal   <= 1'b0;
      vram_addr   <= 16'h0000;
      vram_we     <= 1'b0;
      vram_wdata  <= 8'h00;
      pal_addr    <= 5'h00;
      pal_we      <= 1'b0;
      pal_wdata   <= 8'h00;
      r_rvalid    <= 1'b0;
      c_rvalid    <= 1'b0;
    end else begin
      if (c_req && !w_c_win) begin
        r_wait_cnt <= (r_wait_cnt >= LP_MAX_WAIT) ? LP_MAX_WAIT : r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= 8'h00;
      end

      vram_we <= 1'b0;
      pal_we  <= 1'b0;
      if (w_any) begin
        if (w_pal_hit) begin
          pal_addr  <= w_pal_idx;
          pal_we    <= w_we;
          pal_wdata <= w_wdata;
        end else begin
          vram_addr  <= {2'b00, w_eff};
          vram_we    <= w_we;
          vram_wdata <= w_wdata;
        end
      end

      r_iss_valid <= w_any && !w_we;
      r_iss_cpu   <= w_c_win;
      r_iss_pal   <= w_pal_hit;

      r_rvalid  <= r_iss_valid && !r_iss_cpu;
      c_rvalid  <= r_iss_valid && r_iss_cpu;
      r_rsp_pal <= r_iss_pal;
    end
  end

  // Memories present data one cycle after the issue stage; steer it with the registered hit bit
  assign w_rdata = r_rsp_pal ? pal_rdata : vram_rdata;
  assign r_rdata = r_rvalid ? w_rdata : 8'h00;
  assign c_rdata = c_rvalid ? w_rdata : 8'h00;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
// Table-driven decode vectors, hand sequences for pipeline corners, random traffic vs reference model.
module tb_vram_arbiter;

  localparam int MAX_WAIT = 8;
  localparam int N_RAND   = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rendering;
  logic        r_req;
  logic [15:0] r_addr;
  logic        r_gnt;
  logic [7:0]  r_rdata;
  logic        r_rvalid;
  logic        c_req;
  logic        c_we;
  logic [15:0] c_addr;
  logic [7:0]  c_wdata;
  logic        c_gnt;
  logic [7:0]  c_rdata;
  logic        c_rvalid;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [4:0]  pal_addr;
  logic        pal_we;
  logic [7:0]  pal_wdata;
  logic [7:0]  pal_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .rendering(rendering),
    .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_rdata(r_rdata), .r_rvalid(r_rvalid),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .pal_addr(pal_addr), .pal_we(pal_we), .pal_wdata(pal_wdata), .pal_rdata(pal_rdata)
  );

  function automatic logic [7:0] vinit(int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  function automatic logic [7:0] pinit(int i);
    return 8'((i * 11 + 128) & 255);
  endfunction

  // Synchronous single-port memories standing in for VRAM and palette RAM
  logic [7:0] vram_mem [0:16383];
  logic [7:0] pal_mem  [0:31];
  logic       mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16384; i++) vram_mem[i] <= vinit(i);
      for (int i = 0; i < 32; i++) pal_mem[i] <= pinit(i);
      vram_rdata <= 8'h00;
      pal_rdata  <= 8'h00;
    end else begin
      if (vram_we) vram_mem[vram_addr[13:0]] <= vram_wdata;
      vram_rdata <= vram_mem[vram_addr[13:0]];
      if (pal_we) pal_mem[pal_addr] <= pal_wdata;
      pal_rdata <= pal_mem[pal_addr];
    end
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_outs"}, {vram_addr, vram_we, vram_wdata, pal_addr, pal_we, pal_wdata}, 64'h0);
    chk({tag, "_req_outs"}, {r_gnt, r_rvalid, r_rdata, c_gnt, c_rvalid, c_rdata}, 64'h0);
  endtask

  // Reference model: flat storage keyed by the canonical location an address resolves to
  logic [7:0] ref_mem [0:16383+32];

  function automatic int ref_key(logic [15:0] a);
    int e;
    int idx;
    e = int'(a) % 16384;
    if (e / 256 == 63) begin
      idx = e % 32;
      if (idx >= 16 && idx % 4 == 0) idx = idx - 16;
      return 16384 + idx;
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom) & 16'hC000;
    case ($urandom_range(0, 2))
      0:       a = a | 16'h3F00 | 16'($urandom_range(0, 31));
      1:       a = a | 16'($urandom_range(0, 63));
      default: a = a | 16'h2000 | 16'($urandom_range(0, 63));
    endcase
    return a;
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic        pal;
    logic [15:0] exp_addr;
  } dec_vec_t;

  typedef struct {
    int         due;
    logic       cpu;
    logic [7:0] data;
  } rsp_t;

  dec_vec_t vecs [11];
  rsp_t     q [$];
  int       mwait;
  logic     exp_cg, exp_rg, exp_rv, exp_cv;
  logic     r_seen, c_seen;
  logic [7:0] exp_d;

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0]  = '{16'h2000, 1'b0, 16'h2000};
    vecs[1]  = '{16'h6005, 1'b0, 16'h2005};
    vecs[2]  = '{16'hC123, 1'b0, 16'h0123};
    vecs[3]  = '{16'h3EFF, 1'b0, 16'h3EFF};
    vecs[4]  = '{16'h3F00, 1'b1, 16'h0000};
    vecs[5]  = '{16'h3F10, 1'b1, 16'h0000};
    vecs[6]  = '{16'h3F14, 1'b1, 16'h0004};
    vecs[7]  = '{16'h3F1C, 1'b1, 16'h000C};
    vecs[8]  = '{16'h3F13, 1'b1, 16'h0013};
    vecs[9]  = '{16'hFF3F, 1'b1, 16'h001F};
    vecs[10] = '{16'h7F18, 1'b1, 16'h0008};

    reset = 1'b1; rendering = 1'b0; mem_init = 1'b1;
    r_req = 1'b0; r_addr = 16'h0; c_req = 1'b0; c_we = 1'b0; c_addr = 16'h0; c_wdata = 8'h0;
    step();
    step();
    samp();
    check_quiet("reset_state");
    mem_init = 1'b0;
    reset = 1'b0;
    step();

    // Reset lands while a CPU read sits in the issue stage
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h2000;
    samp();
    chk("t1_c_gnt", c_gnt, 1'b1);
    step();
    c_req = 1'b0;
    reset = 1'b1;
    samp();
    check_quiet("t1_in_reset");
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      samp();
      chk("t1_no_rvalid", {c_rvalid, r_rvalid}, 2'b00);
      step();
    end

    for (int i = 0; i < 11; i++) begin
      c_req = 1'b1; c_we = 1'b1; c_addr = vecs[i].addr; c_wdata = 8'(8'h40 + i);
      samp();
      chk("dec_c_gnt", {c_gnt, r_gnt}, 2'b10);
      step();
      c_req = 1'b0;
      samp();
      if (vecs[i].pal) begin
        chk("dec_pal", {pal_we, pal_addr, pal_wdata, vram_we}, {1'b1, vecs[i].exp_addr[4:0], 8'(8'h40 + i), 1'b0});
      end else begin
        chk("dec_vram", {vram_we, vram_addr, vram_wdata, pal_we}, {1'b1, vecs[i].exp_addr, 8'(8'h40 + i), 1'b0});
      end
      step();
      samp();
      chk("dec_we_pulse", {vram_we, pal_we}, 2'b00);
      step();
    end

    // Palette write through a mirror, then read back via the aliased entry
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h3F10; c_wdata = 8'h2A;
    samp();
    chk("t2_wr_gnt", c_gnt, 1'b1);
    step();
    c_we = 1'b0; c_addr = 16'h3F00;
    samp();
    chk("t2_rd_gnt", c_gnt, 1'b1);
    chk("t2_pal_wr", {pal_we, pal_addr, pal_wdata, vram_we}, {1'b1, 5'h00, 8'h2A, 1'b0});
    step();
    c_req = 1'b0;
    samp();
    chk("t2_early", {c_rvalid, pal_we, vram_we}, 3'b000);
    step();
    samp();
    chk("t2_rdata", {c_rvalid, c_rdata, vram_we}, {1'b1, 8'h2A, 1'b0});
    step();
    samp();
    chk("t2_pulse", c_rvalid, 1'b0);
    step();

    // VRAM mirror write followed immediately by a render read of the same byte
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h6005; c_wdata = 8'h11;
    samp();
    chk("t3_wr_gnt", c_gnt, 1'b1);
    step();
    c_req = 1'b0; rendering = 1'b1; r_req = 1'b1; r_addr = 16'h2005;
    samp();
    chk("t3_vram_wr", {vram_we, vram_addr, vram_wdata, r_gnt}, {1'b1, 16'h2005, 8'h11, 1'b1});
    step();
    r_req = 1'b0;
    samp();
    chk("t3_early", {r_rvalid, vram_we}, 2'b00);
    step();
    samp();
    chk("t3_rdata", {r_rvalid, r_rdata}, {1'b1, 8'h11});
    step();
    samp();
    chk("t3_pulse", r_rvalid, 1'b0);
    step();

    // Starvation bound: two consecutive rounds prove the wait counter restarts from zero
    rendering = 1'b1; r_req = 1'b1; r_addr = 16'h0000;
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h2000;
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int j = 0; j <= MAX_WAIT; j++) begin
        samp();
        chk("t4_gnts", {r_gnt, c_gnt}, {(j < MAX_WAIT), (j == MAX_WAIT)});
        step();
      end
    end
    c_req = 1'b0;
    samp();
    chk("t4_resume", {r_gnt, c_gnt}, 2'b10);
    step();

    rendering = 1'b0; r_req = 1'b1; r_addr = 16'h0001;
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0002;
    samp();
    chk("t5_cpu_first", {r_gnt, c_gnt}, 2'b01);
    step();
    c_req = 1'b0;
    samp();
    chk("t5_render_after", {r_gnt, c_gnt}, 2'b10);
    step();
    r_req = 1'b0;
    step();
    step();
    step();

    rendering = 1'b1;
    for (int k = 0; k < 5; k++) begin
      r_req = (k < 3);
      r_addr = 16'(k);
      samp();
      chk("t6_r_gnt", r_gnt, (k < 3));
      chk("t6_r_rvalid", r_rvalid, (k >= 2));
      if (k >= 2) chk("t6_r_rdata", r_rdata, vinit(k - 2));
      step();
    end

    // Random traffic against the reference model
    r_req = 1'b0; c_req = 1'b0;
    mem_init = 1'b1;
    step();
    mem_init = 1'b0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = vinit(i);
    for (int i = 0; i < 32; i++) ref_mem[16384 + i] = pinit(i);
    mwait = 0;
    r_seen = 1'b0;
    c_seen = 1'b0;
    q.delete();
    for (int k = 0; k < N_RAND + 4; k++) begin
      if (k >= N_RAND) begin
        r_req = 1'b0;
        c_req = 1'b0;
      end else begin
        if (!r_req || r_seen) begin
          r_req = ($urandom_range(0, 3) != 0);
          r_addr = rand_addr();
        end else if ($urandom_range(0, 15) == 0) begin
          r_req = 1'b0;
        end
        if (!c_req || c_seen) begin
          c_req = ($urandom_range(0, 2) != 0);
          c_we = $urandom_range(0, 1) == 1;
          c_addr = rand_addr();
          c_wdata = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          c_req = 1'b0;
        end
        if ($urandom_range(0, 15) == 0) rendering = ~rendering;
      end
      samp();
      exp_rv = 1'b0; exp_cv = 1'b0; exp_d = 8'h00;
      if (q.size() > 0 && q[0].due == k) begin
        exp_d = q[0].data;
        if (q[0].cpu) exp_cv = 1'b1;
        else exp_rv = 1'b1;
        void'(q.pop_front());
      end
      chk("rnd_rvalids", {r_rvalid, c_rvalid}, {exp_rv, exp_cv});
      if (exp_rv) chk("rnd_r_rdata", r_rdata, exp_d);
      if (exp_cv) chk("rnd_c_rdata", c_rdata, exp_d);
      exp_cg = c_req && (!rendering || !r_req || mwait >= MAX_WAIT);
      exp_rg = r_req && !exp_cg;
      chk("rnd_gnts", {r_gnt, c_gnt}, {exp_rg, exp_cg});
      if (exp_cg) begin
        if (c_we) ref_mem[ref_key(c_addr)] = c_wdata;
        else q.push_back('{k + 2, 1'b1, ref_mem[ref_key(c_addr)]});
      end else if (exp_rg) begin
        q.push_back('{k + 2, 1'b0, ref_mem[ref_key(r_addr)]});
      end
      if (c_req && !exp_cg) mwait = (mwait < MAX_WAIT) ? mwait + 1 : MAX_WAIT;
      else mwait = 0;
      r_seen = exp_rg;
      c_seen = exp_cg;
      step();
    end
    chk("rnd_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port VRAM and the palette memory between two requesters: the background/sprite render fetch engine and the CPU register interface (PPUDATA reads/writes).
- Decodes the PPU address space, applies the palette mirroring, issues at most one memory access per cycle and routes read data back to the owning requester.
- Sits between ppu_render / the register block and the VRAM and palette_mem instances in the PPU top level.

Parameters:
MAX_WAIT, 8, cycles a pending CPU request may lose arbitration before it is forced to win the next one (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rendering  in  1  1 = render engine has priority; 0 = CPU has priority
r_req  in  1  render fetch request (read only)
r_addr  in  16  render fetch address
r_gnt  out  1  render request accepted this cycle
r_rdata  out  8  render read data
r_rvalid  out  1  r_rdata valid
c_req  in  1  CPU access request
c_we  in  1  CPU write (1) / read (0)
c_addr  in  16  CPU address
c_wdata  in  8  CPU write data
c_gnt  out  1  CPU request accepted this cycle
c_rdata  out  8  CPU read data
c_rvalid  out  1  c_rdata valid (reads only)
vram_addr  out  16  VRAM address
vram_we  out  1  VRAM write enable
vram_wdata  out  8  VRAM write data
vram_rdata  in  8  VRAM read data (synchronous, 1 cycle)
pal_addr  out  5  palette index
pal_we  out  1  palette write enable
pal_wdata  out  8  palette write data
pal_rdata  in  8  palette read data (synchronous, 1 cycle)

Behaviour:
- Reset: every output 0, wait counter 0, pipeline valid bits 0. An access in flight when reset asserts is discarded; no rvalid follows it.
- Address: effective = addr[13:0] ($4000-$FFFF mirror down). Palette hit when effective[13:8] == 6'h3F. Otherwise it is a VRAM access with vram_addr = {2'b00, effective}.
- Palette index = effective[4:0]. Indices 5'h10/14/18/1C map to 5'h00/04/08/0C.
- Arbitration, cycle N (combinational): at most one winner.
  - rendering=1: render wins unless wait_cnt == MAX_WAIT, in which case the CPU wins.
  - rendering=0: CPU wins; render is granted only when c_req=0.
  - The winner's gnt is high in cycle N (combinational); the loser's gnt stays low.
- Issue stage: at the edge ending N, the winner's address, we and wdata are registered onto the vram_* or pal_* outputs and are valid in N+1. The unselected memory has we=0 and holds its address. With no winner, both we=0.
- Response stage: the memory registers read data at the end of N+1. The owner's rvalid and rdata are valid in N+2 and are registered, one-cycle pulse.
  - rdata is taken from pal_rdata or vram_rdata according to the stored hit bit.
  - Writes produce no rvalid.
- Latency: req -> rvalid = 2 cycles. Throughput is 1 access/cycle, and back-to-back grants to either requester are legal.
- Requester rule: hold req, addr, we and wdata stable until gnt is seen. A new request may be presented in the cycle after gnt. Deasserting req before gnt withdraws it silently.
- Wait counter (8 bit): increments each cycle with c_req=1 and c_gnt=0, saturating at MAX_WAIT. Clears on c_gnt or c_req=0.
- rendering toggling mid-request affects only the next cycle's arbitration. Already-issued accesses always complete.
- Simultaneous write and read to the same address in consecutive cycles: the read returns the newly written data, because issue order equals memory order.

Test Plan:
1. Reset mid-read: c_req read $2000, gnt, then reset in N+1. Required: c_rvalid never pulses and all outputs read 0 during reset.
2. CPU write $3F10 <= 8'h2A with rendering=0, then CPU read $3F00. Required: pal_we pulse with pal_addr=0 and pal_wdata=2A; c_rvalid 2 cycles after the read gnt with c_rdata=8'h2A; vram_we never asserted.
3. Mirror: CPU write $6005 <= 8'h11. Required: vram_addr=16'h2005, vram_we=1 for one cycle. A subsequent render read of $2005 returns r_rdata=8'h11 with r_rvalid exactly 2 cycles after r_gnt.
4. Contention, rendering=1, MAX_WAIT=8: r_req held high continuously and c_req asserted at cycle 0. Required: r_gnt high for cycles 0-7, c_gnt high at cycle 8 with r_gnt low that cycle, then r_gnt resumes; wait counter returns to 0.
5. Priority, rendering=0: r_req and c_req both high. Required: c_gnt first, r_gnt only in a cycle with c_req=0.
6. Back-to-back render reads of $0000, $0001, $0002 at 1/cycle. Required: three consecutive r_rvalid pulses, in order, matching the preloaded VRAM bytes.
